// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and decode handshake.
// The master modport is the fetch unit's view; the slave modport is the memory/decode side.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               PCSrc;
  logic [ADDR_W-1:0]  BranchAddress;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] Instruction;
  logic [ADDR_W-1:0]  Address;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, Instruction, Address,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, PCSrc, BranchAddress, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, Instruction, Address,
    output imem_req_ready, imem_resp_valid, imem_resp_data, PCSrc, BranchAddress, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order reads to instruction memory, buffers returned words in
// a prefetch FIFO and hands {Instruction, Address} to decode. A redirect flushes everything in flight.
module instruction_fetch #(
  parameter int unsigned      ADDR_W     = 64,
  parameter int unsigned      INSTR_W    = 32,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic                  clk,
  input logic                  reset,
  instruction_fetch_if.master  bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [CntW-1:0]    outst_q, outst_d;
  logic [CntW-1:0]    drop_q, drop_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0] instr_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  addr_mem_q  [FIFO_DEPTH];

  logic [CntW:0]      in_use;
  logic               req_valid;
  logic               req_fire;
  logic               resp_drop;
  logic               wr_en;
  logic               pop;
  logic [ADDR_W-1:0]  target;

  // Credit rule: FIFO entries plus in-flight requests never exceed the FIFO depth.
  assign in_use    = {1'b0, count_q} + {1'b0, outst_q};
  assign req_valid = !reset && !bus.PCSrc && (in_use < DepthC);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign resp_drop = bus.imem_resp_valid && (drop_q != '0);
  assign wr_en     = bus.imem_resp_valid && (drop_q == '0) && !bus.PCSrc;
  assign pop       = bus.instr_valid && bus.instr_ready && !bus.PCSrc;
  assign target    = bus.BranchAddress & ~ADDR_W'(3);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = (count_q != '0);
  assign bus.Instruction    = bus.instr_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.Address        = bus.instr_valid ? addr_mem_q[rd_ptr_q] : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    outst_d    = outst_q + CntW'(req_fire) - CntW'(bus.imem_resp_valid);
    count_d    = count_q + CntW'(wr_en) - CntW'(pop);
    drop_d     = drop_q - CntW'(resp_drop);

    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (wr_en) begin
      resp_pc_d = resp_pc_q + ADDR_W'(4);
      wr_ptr_d  = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);

    // Every request still in flight after this cycle belongs to the old path; a response
    // arriving right now is discarded directly and is already gone from outst_d.
    if (bus.PCSrc) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_resp_data;
      addr_mem_q[wr_ptr_q]  <= resp_pc_q;
    end
  end
endmodule
